// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one ALU32Bit among N_REQ requesters.
// One operation in flight; result is captured ALU_LAT+1 cycles after accept.
module alu_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [4*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  busy,
  output logic [3:0]            ALUControl,
  output logic [31:0]           A,
  output logic [31:0]           B,
  input  logic [31:0]           ALUResult,
  input  logic                  Zero
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 3;

  // state | meaning: IDLE = arbitrating, WAIT = ALU latency, RESP = result held for requester
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_gnt;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_alu_ctl;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_rsp_result;
  logic             r_rsp_zero;
  logic [N_REQ-1:0] r_rsp_valid;

  logic             w_found;
  logic [IDX_W-1:0] w_gnt;
  logic [IDX_W-1:0] w_next_ptr;
  int               w_dist;
  int               w_best;
  logic [N_REQ-1:0] w_sel_oh;
  logic [N_REQ-1:0] w_gnt_oh;
  logic             w_rsp_ack;
  logic [3:0]       w_op;
  logic [31:0]      w_a;
  logic [31:0]      w_b;

  // Pick the valid requester with the smallest distance from the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_dist  = 0;
    w_best  = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = i - int'(r_rr_ptr);
      if (w_dist < 0) w_dist = w_dist + N_REQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_gnt   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_oh  = '0;
    w_gnt_oh  = '0;
    w_rsp_ack = 1'b0;
    w_op      = '0;
    w_a       = '0;
    w_b       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt == IDX_W'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_op        = req_op[4*i +: 4];
        w_a         = req_a[32*i +: 32];
        w_b         = req_b[32*i +: 32];
      end
      if (r_gnt == IDX_W'(i)) begin
        w_gnt_oh[i] = 1'b1;
        w_rsp_ack   = rsp_ready[i];
      end
    end
  end

  always_comb begin
    w_next_ptr = w_gnt + 1'b1;
    if (int'(w_gnt) == N_REQ - 1) w_next_ptr = '0;
  end

  assign req_ready = (r_state == S_IDLE && w_found) ? w_sel_oh : '0;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_alu_ctl    <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_valid  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_alu_ctl <= w_op;
            r_a       <= w_a;
            r_b       <= w_b;
            r_gnt     <= w_gnt;
            r_rr_ptr  <= w_next_ptr;
            r_cnt     <= CNT_W'(ALU_LAT);
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_result <= ALUResult;
            r_rsp_zero   <= Zero;
            r_rsp_valid  <= w_gnt_oh;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_ack) begin
            r_rsp_valid <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign ALUControl = r_alu_ctl;
  assign A          = r_a;
  assign B          = r_b;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: ALU_LAT=1 main instance plus
// ALU_LAT=0 and ALU_LAT=3 instances for latency checks.
module tb_alu_share_arbiter;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4*N-1:0]  req_op;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     rsp_result, A, B, ALUResult;
  logic            rsp_zero, busy, Zero;
  logic [3:0]      ALUControl;

  // ALU_LAT=1 registered adder stub
  always @(posedge CLK) ALUResult <= A + B;
  assign Zero = (ALUResult == 32'd0);

  alu_share_arbiter #(.N_REQ(N), .ALU_LAT(1)) dut (
    .CLK(CLK), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .busy(busy), .ALUControl(ALUControl), .A(A), .B(B),
    .ALUResult(ALUResult), .Zero(Zero));

  // Latency-sweep instances share operand buses but have their own valid.
  logic [N-1:0] s_valid;
  logic [N-1:0] s_rdy_all;
  logic [N-1:0] s0_req_ready, s0_rsp_valid, s3_req_ready, s3_rsp_valid;
  logic [31:0]  s0_res, s0_A, s0_B, s0_alu, s3_res, s3_A, s3_B, s3_alu;
  logic [31:0]  p1, p2, p3;
  logic         s0_zero, s0_busy, s0_Z, s3_zero, s3_busy, s3_Z;
  logic [3:0]   s0_ctl, s3_ctl;

  assign s0_alu = s0_A + s0_B;
  assign s0_Z   = (s0_alu == 32'd0);
  always @(posedge CLK) begin
    p1 <= s3_A + s3_B;
    p2 <= p1;
    p3 <= p2;
  end
  assign s3_alu = p3;
  assign s3_Z   = (p3 == 32'd0);

  alu_share_arbiter #(.N_REQ(N), .ALU_LAT(0)) dut_l0 (
    .CLK(CLK), .Reset(Reset), .req_valid(s_valid), .req_ready(s0_req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(s0_rsp_valid),
    .rsp_ready(s_rdy_all), .rsp_result(s0_res), .rsp_zero(s0_zero),
    .busy(s0_busy), .ALUControl(s0_ctl), .A(s0_A), .B(s0_B),
    .ALUResult(s0_alu), .Zero(s0_Z));

  alu_share_arbiter #(.N_REQ(N), .ALU_LAT(3)) dut_l3 (
    .CLK(CLK), .Reset(Reset), .req_valid(s_valid), .req_ready(s3_req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(s3_rsp_valid),
    .rsp_ready(s_rdy_all), .rsp_result(s3_res), .rsp_zero(s3_zero),
    .busy(s3_busy), .ALUControl(s3_ctl), .A(s3_A), .B(s3_B),
    .ALUResult(s3_alu), .Zero(s3_Z));

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t sb_q[$];
  int   hs_cyc[$];
  exp_t e_mon;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic push_exp(input int id, input logic [31:0] res, input logic z);
    exp_t e;
    e.id = id; e.res = res; e.z = z;
    sb_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*i +: 4]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_neg(input int n);
    for (int k = 0; k < n; k++) @(negedge CLK);
  endtask

  // Monitor: pops one expectation per response handshake.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if ((rsp_valid & rsp_ready) != '0) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with no response expected", rsp_valid);
        end else begin
          e_mon = sb_q.pop_front();
          chk("rsp_route", 32'(rsp_valid), 32'(4'b0001 << e_mon.id));
          chk("rsp_result", rsp_result, e_mon.res);
          chk("rsp_zero", 32'(rsp_zero), 32'(e_mon.z));
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  int t0, t3;
  logic [31:0] r0, r3;

  initial begin
    req_valid = '0; rsp_ready = '1; req_op = '0; req_a = '0; req_b = '0;
    s_valid = '0; s_rdy_all = '1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_ctl", 32'(ALUControl), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    wait_neg(2);
    Reset = 1'b0;

    // single request from req0
    @(negedge CLK);
    set_req(0, 4'd2, 32'd5, 32'd7);
    req_valid = 4'b0001;
    push_exp(0, 32'd12, 1'b0);
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    @(negedge CLK);
    req_valid = '0;
    #1;
    chk("t1_A", A, 32'd5);
    chk("t1_B", B, 32'd7);
    chk("t1_ctl", 32'(ALUControl), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    #1 chk("t1_wait_novalid", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    #1 chk("t1_rsp_valid", 32'(rsp_valid), 32'b0001);
    @(negedge CLK);
    #1 chk("t1_idle", 32'(busy), 32'd0);

    // all four requesters valid after reset: grants 0,1,2,3,0 every 4 cycles
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    hs_cyc.delete();
    set_req(0, 4'd0, 32'd3, 32'd4);
    set_req(1, 4'd1, 32'd100, 32'd200);
    set_req(2, 4'd2, 32'd1000, 32'd2000);
    set_req(3, 4'd6, 32'd40000, 32'd2);
    push_exp(0, 32'd7, 1'b0);
    push_exp(1, 32'd300, 1'b0);
    push_exp(2, 32'd3000, 1'b0);
    push_exp(3, 32'd40002, 1'b0);
    push_exp(0, 32'd7, 1'b0);
    req_valid = 4'b1111;
    #1 chk("t2_first_ready", 32'(req_ready), 32'b0001);
    wait_neg(18);
    req_valid = '0;
    wait_neg(4);
    chk("t2_hs_count", 32'(hs_cyc.size()), 32'd5);
    for (int i = 1; i < 5; i++)
      if (i < hs_cyc.size()) chk("t2_interval", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd4);

    // zero flag on req2 (rr_ptr=1 searches 1,2)
    @(negedge CLK);
    set_req(2, 4'd2, 32'hFFFF_FFFF, 32'd1);
    req_valid = 4'b0100;
    push_exp(2, 32'd0, 1'b1);
    #1 chk("t3_ready", 32'(req_ready), 32'b0100);
    @(negedge CLK);
    req_valid = '0;
    wait_neg(4);

    // back-pressure on req1 while req0/req3 wait
    set_req(1, 4'd2, 32'd20, 32'd22);
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    push_exp(1, 32'd42, 1'b0);
    push_exp(3, 32'd18, 1'b0);
    push_exp(0, 32'd2, 1'b0);
    #1 chk("t4_ready1", 32'(req_ready), 32'b0010);
    @(negedge CLK);
    set_req(0, 4'd0, 32'd1, 32'd1);
    set_req(3, 4'd0, 32'd9, 32'd9);
    req_valid = 4'b1001;
    wait_neg(2);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_hold_valid", 32'(rsp_valid), 32'b0010);
      chk("t4_hold_result", rsp_result, 32'd42);
      chk("t4_no_ready", 32'(req_ready), 32'd0);
      chk("t4_hold_A", A, 32'd20);
      @(negedge CLK);
    end
    rsp_ready = 4'b1111;
    @(negedge CLK);
    #1 chk("t4_next_grant", 32'(req_ready), 32'b1000);
    @(negedge CLK);
    req_valid = 4'b0001;
    wait_neg(4);
    req_valid = '0;
    wait_neg(5);

    // reset during WAIT
    set_req(0, 4'd3, 32'd50, 32'd50);
    req_valid = 4'b0001;
    @(negedge CLK);
    req_valid = '0;
    #1 chk("t5_busy_before", 32'(busy), 32'd1);
    Reset = 1'b1;
    #1;
    chk("t5_A", A, 32'd0);
    chk("t5_B", B, 32'd0);
    chk("t5_ctl", 32'(ALUControl), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rsp_result", rsp_result, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    wait_neg(2);
    Reset = 1'b0;
    set_req(1, 4'd2, 32'd7, 32'd8);
    req_valid = 4'b0010;
    push_exp(1, 32'd15, 1'b0);
    #1 chk("t5_regrant", 32'(req_ready), 32'b0010);
    @(negedge CLK);
    req_valid = '0;
    wait_neg(4);

    // latency sweep: ALU_LAT=0 responds at E0+1, ALU_LAT=3 at E0+4
    set_req(0, 4'd2, 32'd1000, 32'd234);
    s_valid = 4'b0001;
    t0 = 0; t3 = 0; r0 = '0; r3 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      s_valid = '0;
      #1;
      if (t0 == 0 && s0_rsp_valid[0]) begin t0 = k; r0 = s0_res; end
      if (t3 == 0 && s3_rsp_valid[0]) begin t3 = k; r3 = s3_res; end
    end
    chk("t6_lat0_time", 32'(t0), 32'd2);
    chk("t6_lat0_result", r0, 32'd1234);
    chk("t6_lat3_time", 32'(t3), 32'd5);
    chk("t6_lat3_result", r3, 32'd1234);

    wait_neg(2);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
